// File: rtl/decimating_averager.sv
// Boxcar decimator: averages 2^k valid samples and emits the floor mean with a one-cycle valid_o.
// Latency is one cycle after the final sample. There is no backpressure: one sample is accepted every clock.
module decimating_averager #(
  parameter int WIDTH    = 16,
  parameter int MAX_LOG2 = 10,
  parameter int LOGW     = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [WIDTH-1:0] data_i,
  input  logic                    valid_i,
  input  logic        [LOGW-1:0]  log2_n_i,
  output logic signed [WIDTH-1:0] out_o,
  output logic                    valid_o,
  output logic                    busy_o
);

  localparam int ACCW = WIDTH + MAX_LOG2;
  localparam logic [LOGW-1:0] K_MAX = LOGW'(MAX_LOG2);

  logic signed [ACCW-1:0]  acc_q, acc_d, sum, shifted;
  logic        [MAX_LOG2-1:0] cnt_q, cnt_d, last_cnt;
  logic        [LOGW-1:0]  k_q, k_d, k_clamp, k_cur;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    valid_q, valid_d;

  always_comb begin
    k_clamp = (log2_n_i > K_MAX) ? K_MAX : log2_n_i;
    // The first sample of a block already uses the newly latched ratio.
    k_cur    = (cnt_q == '0) ? k_clamp : k_q;
    last_cnt = ~({MAX_LOG2{1'b1}} << k_cur);
    sum      = acc_q + {{MAX_LOG2{data_i[WIDTH-1]}}, data_i};
    shifted  = sum >>> k_cur;

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    out_d   = out_q;
    valid_d = 1'b0;

    if (valid_i) begin
      if (cnt_q == '0) begin
        k_d = k_clamp;
      end
      if (cnt_q == last_cnt) begin
        out_d   = shifted[WIDTH-1:0];
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_o   = out_q;
  assign valid_o = valid_q;
  assign busy_o  = (cnt_q != '0);

endmodule
